// File: rtl/shift_buffer.sv
// Receive frame buffer: samples rfin once per sh_en strobe, shifts into a
// frame register, and holds a sync-aligned frame on a valid/ready handshake.
module shift_buffer #(
    parameter int                   FRAME_LEN = 64,
    parameter logic [FRAME_LEN-1:0] SYNC_MASK = 64'h7C00_001F_0000_0000,
    parameter logic [FRAME_LEN-1:0] SYNC_VAL  = 64'h7C00_001F_0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rfin,
    input  logic                 sh_en,
    input  logic                 RX,
    input  logic                 tx_rdy,
    output logic [FRAME_LEN-1:0] frame_data,
    output logic                 frame_vld,
    output logic [7:0]           frame_cnt,
    output logic                 hunting
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] CNT_FULL = 7'(FRAME_LEN);

    state_t               state;
    state_t               state_next;
    logic                 rfin_meta;
    logic                 rfin_sync;
    logic                 rfin_prev;
    logic                 rfin_edge;
    logic                 hit;
    logic [6:0]           bit_cnt;
    logic [FRAME_LEN-1:0] shreg;
    logic                 match;

    assign rfin_edge = rfin_sync & ~rfin_prev;
    assign match     = (bit_cnt == CNT_FULL) && ((shreg & SYNC_MASK) == SYNC_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rfin_meta <= 1'b0;
            rfin_sync <= 1'b0;
            rfin_prev <= 1'b0;
        end else begin
            rfin_meta <= rfin;
            rfin_sync <= rfin_meta;
            rfin_prev <= rfin_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // RX loss in HUNT takes priority over a coinciding match; HOLD ignores RX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (RX) state_next = HUNT;
            HUNT: begin
                if (!RX)        state_next = IDLE;
                else if (match) state_next = HOLD;
            end
            HOLD: if (tx_rdy) state_next = RX ? HUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An edge arriving in the strobe cycle belongs to the bit being shifted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            hit       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (!RX) begin
                        bit_cnt <= '0;
                        hit     <= 1'b0;
                    end else if (sh_en) begin
                        shreg <= {shreg[FRAME_LEN-2:0], hit | rfin_edge};
                        hit   <= 1'b0;
                        if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + 7'd1;
                    end else if (rfin_edge) begin
                        hit <= 1'b1;
                    end
                end
                HOLD: begin
                    hit <= 1'b0;
                    if (tx_rdy) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        bit_cnt   <= '0;
                    end
                end
                default: hit <= 1'b0;
            endcase
        end
    end

    assign frame_data = shreg;
    assign frame_vld  = (state == HOLD);
    assign hunting    = (state == HUNT);

endmodule

// File: doc/shift_buffer.md
# shift_buffer

Receive-side frame buffer that sits directly downstream of `SH_SYNC`. It samples the RF pulse input `rfin` into one bit per `sh_en` strobe, shifts the bits into a 64-bit register and hunts for the sync pattern. When a complete frame aligns, it freezes the register and holds it on a valid/ready handshake until the transmit side (`tx_rdy`) takes it.

## Interface
- `FRAME_LEN`, 64: frame width in bits; also the shift-register depth.
- `SYNC_MASK`, 64'h7C00_001F_0000_0000: bit positions checked for sync (62..58 and 36..32).
- `SYNC_VAL`, 64'h7C00_001F_0000_0000: required value at masked positions.
- `clk`  in  1  system clock (10 MHz nominal).
- `rst`  in  1  reset, asynchronous, active-low.
- `rfin`  in  1  asynchronous RF pulse, ≥1 clk wide.
- `sh_en`  in  1  one-cycle bit-boundary strobe from `SH_SYNC`.
- `RX`  in  1  receive-mode enable (level).
- `tx_rdy`  in  1  downstream ready; accepts the frame when high together with `frame_vld`.
- `frame_data`  out  FRAME_LEN  shift register contents; MSB is the oldest bit.
- `frame_vld`  out  1  frame held and valid.
- `frame_cnt`  out  8  count of accepted frames; wraps 255→0.
- `hunting`  out  1  high in HUNT state.

## Operation
- **rfin front end.** 2-flop synchronizer, then a rising-edge detector on the synced signal. The `hit` latch sets on a detected edge. If `sh_en` and an edge occur in the same cycle, the edge belongs to the bit being shifted.
- **Bit shift.** In HUNT, on `sh_en`:
  - `shreg <= {shreg[FRAME_LEN-2:0], hit | edge}`
  - `hit` clears
  - `bit_cnt` increments, saturating at FRAME_LEN (7-bit counter)
- **Match condition.** `match = (bit_cnt == FRAME_LEN) && ((shreg & SYNC_MASK) == SYNC_VAL)`, evaluated on registered values.
- **FSM states.** IDLE, HUNT, HOLD.
  - IDLE: `RX`=1 → HUNT. `sh_en` and rfin edges are ignored; `hit` is held clear.
  - HUNT: `RX`=0 → IDLE, clearing `bit_cnt` and `hit`; `shreg` is retained. Otherwise `match` → HOLD. If `RX` falls in the same cycle as `match`, `RX` wins and the next state is IDLE.
  - HOLD: `shreg` is frozen, `sh_en` ignored, `hit` held clear, `frame_vld`=1. `RX` is ignored, so a held frame survives `RX` dropping. On `tx_rdy`=1:
    - `frame_cnt` increments;
    - `bit_cnt` clears;
    - next state is HUNT if `RX`=1, else IDLE.
- **Outputs.** `frame_vld` = (state==HOLD) and `hunting` = (state==HUNT), both decoded from registered state. `frame_data` = `shreg`.
- **Reset.** Asserting `rst` low at any time (mid-shift or in HOLD) immediately clears all state, including synchronizer flops. The held frame is discarded.

## Timing
- Reset values:
  - `frame_data`=0, `frame_vld`=0, `frame_cnt`=0, `hunting`=0
  - state=IDLE, `bit_cnt`=0, `hit`=0
- `RX` high sampled at edge N → `hunting`=1 after edge N.
- `rfin` rising edge to edge-detect pulse: 2–3 clk (synchronizer uncertainty).
- `sh_en` high in cycle N → `shreg`/`bit_cnt` update at edge N+1. `match` is evaluated in cycle N+1, giving HOLD and `frame_vld`=1 after edge N+2. Shift-to-valid latency is 2 clk.
- Handshake: accept occurs in the cycle where `frame_vld`=1 and `tx_rdy`=1. `frame_vld` deasserts after the next edge and `frame_cnt` updates on the same edge. `tx_rdy` has no effect outside HOLD.
- Back-to-back frames need FRAME_LEN new shifts after accept; no frame is detected on fewer.
- `sh_en` is never expected on consecutive cycles. If it is, each pulse still shifts one bit.

## Test plan
- **Reset and idle.** Hold `rst`=0 for 2 clk, then `rst`=1 with `RX`=0, pulse `sh_en` 10× with `rfin` pulses → `frame_data`=0, `frame_vld`=0, `hunting`=0, `frame_cnt`=0.
- **Nominal frame.** `RX`=1, `sh_en` every 20 clk. Send the 73-bit stream: `10`, 8×`1`, `11111`, 21 bits `011101010011101100010`, `11111`, 23 bits `01010110010101101101010`, 9×`1`. Each 1 is a 1-clk `rfin` pulse 5 clk after `sh_en` → `frame_vld` rises exactly 2 clk after the first `sh_en` whose shift makes bits 62..58 and 36..32 all 1; `frame_data` matches the reference model. Then set `RX`=0, and set `tx_rdy`=1 500 ns later → `frame_vld` stays 1 until `tx_rdy`, then 0; `frame_cnt`=1; state IDLE.
- **Sync miss.** Same stream with bit 34 forced to 0 → no `frame_vld` through end of stream; `bit_cnt` saturates at 64.
- **Abort.** Drop `RX` after 30 shifts, then restore `RX` and send a full valid stream → detection requires 64 fresh shifts; no early `frame_vld`.
- **Edge/strobe coincidence.** Align the `rfin` synced edge with the `sh_en` cycle → the bit shifts in as 1 and the next bit is 0.
- **Reset in HOLD.** While `frame_vld`=1, pulse `rst` low for 1 clk → all outputs 0 immediately; `frame_cnt` stays 0.
